// File: rtl/mac_audio_pkg.sv
`default_nettype none
// ============================================================================
// mac_audio_pkg : shared types, widths and defaults for the audio resampler
// Rev 1.0
// ============================================================================
package mac_audio_pkg;

  localparam int IN_W       = 11;
  localparam int OUT_W      = 16;
  localparam int FRAC_W     = 8;
  localparam int CNT_W      = 16;
  localparam int ACC_W      = 26;
  localparam int DIVD_W     = CNT_W + FRAC_W;
  localparam int PROD_W     = IN_W + FRAC_W + 2;
  localparam int MIN_PERIOD = 64;

  localparam int DEF_CLK_HZ     = 32500000;
  localparam int DEF_OUT_HZ     = 48000;
  localparam int DEF_NOM_PERIOD = 1460;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    MUL  = 2'd2,
    OUT  = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_audio_resampler_if.sv
`default_nettype none
// ============================================================================
// mac_audio_resampler_if : sample input / PCM output bundle
// Rev 1.0
// ============================================================================
interface mac_audio_resampler_if;
  import mac_audio_pkg::*;

  logic signed [IN_W-1:0]  sample_in;
  logic                    sample_valid;
  logic signed [OUT_W-1:0] pcm_out;
  logic                    pcm_strobe;

  modport master (output sample_in, output sample_valid, input pcm_out, input pcm_strobe);
  modport slave  (input sample_in, input sample_valid, output pcm_out, output pcm_strobe);
endinterface
`default_nettype wire

// File: rtl/frac_divider.sv
`default_nettype none
// ============================================================================
// frac_divider : 8-step restoring divider, one quotient bit per cycle MSB first
// Rev 1.0
// ============================================================================
module frac_divider
  import mac_audio_pkg::*;
(
  input  logic              clk32,
  input  logic              reset,
  input  logic              start,
  input  logic [DIVD_W-1:0] dividend,
  input  logic [CNT_W-1:0]  divisor,
  input  logic              force_max,
  output logic [FRAC_W-1:0] quotient,
  output logic              done
);
  logic [CNT_W-1:0]  rem;
  logic [FRAC_W-1:0] low;
  logic [FRAC_W-1:0] q;
  logic [2:0]        step;
  logic              busy;
  logic              forced;
  logic [CNT_W:0]    trial;
  logic [CNT_W-1:0]  diff;

  // The upper dividend half is below the divisor unless forced, so the
  // remainder after subtraction always fits CNT_W bits.
  always_comb begin
    trial = {rem, low[FRAC_W-1]};
    diff  = trial[CNT_W-1:0] - divisor;
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      rem    <= '0;
      low    <= '0;
      q      <= '0;
      step   <= '0;
      busy   <= 1'b0;
      forced <= 1'b0;
    end else if (start) begin
      rem    <= dividend[DIVD_W-1:FRAC_W];
      low    <= dividend[FRAC_W-1:0];
      q      <= '0;
      step   <= '0;
      busy   <= 1'b1;
      forced <= force_max;
    end else if (busy) begin
      if (trial >= {1'b0, divisor}) begin
        rem <= diff;
        q   <= {q[FRAC_W-2:0], 1'b1};
      end else begin
        rem <= trial[CNT_W-1:0];
        q   <= {q[FRAC_W-2:0], 1'b0};
      end
      low  <= {low[FRAC_W-2:0], 1'b0};
      step <= step + 3'd1;
      if (step == 3'd7) busy <= 1'b0;
    end
  end

  assign done     = busy && (step == 3'd7);
  assign quotient = forced ? '1 : q;

endmodule
`default_nettype wire

// File: rtl/mac_audio_resampler.sv
`default_nettype none
// ============================================================================
// mac_audio_resampler : Mac sound stream to fixed-rate interpolated PCM
// Rev 1.0
// ============================================================================
module mac_audio_resampler
  import mac_audio_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int OUT_HZ     = DEF_OUT_HZ,
  parameter int NOM_PERIOD = DEF_NOM_PERIOD
) (
  input logic                  clk32,
  input logic                  reset,
  mac_audio_resampler_if.slave aud
);
  logic [ACC_W-1:0]         acc;
  logic [ACC_W:0]           acc_sum;
  logic                     tick;
  logic signed [IN_W-1:0]   prev, cur, snap_a, snap_b, res, res_nx;
  logic signed [IN_W-1:0]   eff_a, eff_b;
  logic [CNT_W-1:0]         elapsed, period, new_period, eff_e, eff_p;
  state_t                   state, state_nx;
  logic                     start, div_done;
  logic [FRAC_W-1:0]        frac;
  logic signed [IN_W:0]     diff;
  logic signed [PROD_W-1:0] prod;

  always_comb begin
    acc_sum = {1'b0, acc} + (ACC_W+1)'(OUT_HZ);
    tick    = acc_sum >= (ACC_W+1)'(CLK_HZ);
  end

  always_ff @(posedge clk32) begin
    if (reset)     acc <= '0;
    else if (tick) acc <= ACC_W'(acc_sum - (ACC_W+1)'(CLK_HZ));
    else           acc <= acc_sum[ACC_W-1:0];
  end

  // Snapshot values as they will look after this cycle's history update,
  // so a sample arriving together with a tick is seen immediately.
  always_comb begin
    new_period = (elapsed >= CNT_W'(MIN_PERIOD)) ? sat_inc(elapsed) : period;
    eff_e = aud.sample_valid ? '0 : elapsed;
    eff_p = aud.sample_valid ? new_period : period;
    eff_a = aud.sample_valid ? cur : prev;
    eff_b = aud.sample_valid ? aud.sample_in : cur;
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      prev    <= '0;
      cur     <= '0;
      elapsed <= '0;
      period  <= CNT_W'(NOM_PERIOD);
    end else if (aud.sample_valid) begin
      prev    <= cur;
      cur     <= aud.sample_in;
      elapsed <= '0;
      period  <= new_period;
    end else begin
      elapsed <= sat_inc(elapsed);
    end
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      IDLE: if (tick) begin
        start    = 1'b1;
        state_nx = DIV;
      end
      DIV:     if (div_done) state_nx = MUL;
      MUL:     state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  frac_divider u_div (
    .clk32     (clk32),
    .reset     (reset),
    .start     (start),
    .dividend  ({eff_e, {FRAC_W{1'b0}}}),
    .divisor   (eff_p),
    .force_max (eff_e >= eff_p),
    .quotient  (frac),
    .done      (div_done)
  );

  // Arithmetic shift floors toward -inf; the result lies between a and b.
  always_comb begin
    diff   = {snap_b[IN_W-1], snap_b} - {snap_a[IN_W-1], snap_a};
    prod   = PROD_W'(diff) * PROD_W'($signed({1'b0, frac}));
    res_nx = IN_W'(PROD_W'(snap_a) + (prod >>> FRAC_W));
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      state  <= IDLE;
      snap_a <= '0;
      snap_b <= '0;
      res    <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        snap_a <= eff_a;
        snap_b <= eff_b;
      end
      if (state == MUL) res <= res_nx;
    end
  end

  assign aud.pcm_out    = {res, {(OUT_W-IN_W){1'b0}}};
  assign aud.pcm_strobe = (state == OUT);

endmodule
`default_nettype wire

// File: doc/mac_audio_resampler.md
# mac_audio_resampler

Converts the Mac sound stream into a fixed-rate PCM stream for the platform audio codec. Input is the 11-bit signed sample (8-bit sample × 3-bit binary volume) from the data controller, updated once per horizontal line (~22.25 kHz). Output is 16-bit signed PCM at OUT_HZ, linearly interpolated between the two most recent input samples. The block sits between the data controller's audio output and the top-level audio mixer.

## Interface
- CLK_HZ, 32500000, clock frequency in Hz (NCO modulus).
- OUT_HZ, 48000, output sample rate in Hz (NCO increment).
- NOM_PERIOD, 1460, input sample period in clocks loaded at reset.
- clk32  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- sample_in  in  11  signed input sample, two's complement.
- sample_valid  in  1  one-cycle pulse: sample_in holds a new sample.
- pcm_out  out  16  signed output sample.
- pcm_strobe  out  1  one-cycle pulse: pcm_out has just updated.

## Operation
- Sample history: on sample_valid, prev ← cur and cur ← sample_in. period ← elapsed+1 when the elapsed count is ≥ 64. Otherwise period is left unchanged, so glitch pulses are rejected. elapsed ← 0.
- elapsed: 16-bit counter, +1 per clock, saturates at 0xFFFF. period: 16-bit register.
- NCO: a 26-bit accumulator adds OUT_HZ every clock. When acc + OUT_HZ ≥ CLK_HZ, it subtracts CLK_HZ and raises an internal tick for 1 cycle.
- States: IDLE, DIV, MUL, OUT.
- IDLE: on tick, snapshot e = elapsed, p = period, a = prev, b = cur, then go to DIV. If e ≥ p, the quotient is forced to 255, but DIV still runs its full length so latency stays fixed.
- DIV: 8-iteration restoring division, frac = (e·256)/p, 8-bit unsigned, truncated. One quotient bit per cycle, MSB first. After 8 cycles go to MUL.
- MUL: d = b − a, 12-bit signed. r = a + ((d · {1'b0,frac}) >>> 8), using arithmetic shift with truncation toward −∞. r fits in 11 bits and is stored as 11 bits. Go to OUT.
- OUT: pcm_out ← {r[10:0], 5'b00000}, pcm_strobe ← 1, go to IDLE.
- A tick that occurs while not in IDLE is dropped. This cannot happen at the default parameters; bench asserts it never does.
- sample_valid is accepted in every state. Snapshots taken at tick are not disturbed.
- The sample_valid and tick in the same cycle: the sample history update takes effect first. The snapshot sees e = 0 and the new prev/cur, so the output equals the new prev.
- No input for 65535+ clocks: elapsed saturates, frac = 255, and output holds at ≈ cur. This gives silence when sound is disabled and the upstream latch holds 0.

## Timing
- Reset values: pcm_out = 0, pcm_strobe = 0, prev = cur = 0, elapsed = 0, period = NOM_PERIOD, acc = 0, state = IDLE.
- Reset asserted mid-DIV or mid-MUL aborts the computation. No strobe is emitted, and all registers take their reset values on the next edge.
- Latency: tick in cycle T → DIV in T+1..T+8 → MUL in T+9 → pcm_strobe high in T+10 with the new pcm_out. This is fixed at 10 cycles.
- pcm_strobe spacing is CLK_HZ/OUT_HZ clocks (677 or 678 at defaults). pcm_out is stable between strobes.
- sample_in is sampled only in cycles where sample_valid = 1.

## Structure
- Package mac_audio_pkg holds:
  - the state enum (IDLE/DIV/MUL/OUT);
  - widths (IN_W = 11, OUT_W = 16, FRAC_W = 8, CNT_W = 16);
  - MIN_PERIOD = 64;
  - the defaults for CLK_HZ, OUT_HZ and NOM_PERIOD.
- Sub-module frac_divider holds the 8-step restoring divider. Interface: start, dividend 24 b, divisor 16 b, force_max → quotient 8 b, done. The NCO, history registers and FSM stay in the top module.

## Test plan
- Reset, then no input for 1 ms → pcm_strobe every 677/678 clocks (48 ± 1 strobes), pcm_out = 0 throughout.
- Constant sample_in = 0x3FF with sample_valid every 1460 clocks → after the 2nd input, every pcm_out = 0x7FE0.
- Ramp: prev = 0, cur = 400, tick forced at elapsed = 730 with period = 1460 → frac = 128, r = 200, pcm_out = 0x1900.
- Negative step: prev = 100, cur = −100, elapsed = 365, period = 1460 → frac = 64, d = −200, r = 100 − 50 = 50, pcm_out = 0x0640.
- Same-cycle sample_valid and tick with new sample −1024, old cur = 300 → pcm_out = 300<<5 = 0x2580 at T+10. The following output interpolates toward −1024.
- Reset pulsed at T+5 after a tick → no pcm_strobe at T+10, pcm_out = 0, period = 1460. A sample_valid pulse 10 clocks after a previous one leaves period unchanged.
